blink_mem_arbiter: RTL and testbench

- Shares the single 22-bit physical memory bus (internal ROM/RAM, slots 1-3) between the Z80 and the LCD refresh fetch engine.
- Grants one access at a time and runs a fixed-length access cycle with chip-enable, output-enable and write strobes.
- Stalls the Z80 clock while a CPU access waits or is in progress.
- Prioritises the CPU but has a starvation guard so LCD refresh never misses a line deadline.

---
 rtl/blink_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_blink_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_mem_arbiter.sv
// Shares the 22-bit memory bus between the Z80 and the LCD fetch engine.
// The CPU has priority; a starvation counter hands the bus to the LCD when it has waited too long.
module blink_mem_arbiter #(
  parameter int ACC_CYCLES = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        lcd_req,
  input  logic [21:0] lcd_addr,
  output logic [7:0]  lcd_rdata,
  output logic        lcd_done,
  output logic [21:0] mem_addr,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, LCD_ACC, TURN} state_t;

  localparam logic [3:0] ACC_LAST   = 4'(ACC_CYCLES - 1);
  localparam logic [3:0] WE_LAST    = 4'(ACC_CYCLES - 2);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [3:0] acc_cnt, acc_nxt;
  logic [7:0] starve_cnt;
  logic       cpu_served;
  logic       acc_we, we_nxt;
  logic       cpu_pend, grant_cpu, grant_lcd, acc_last, in_acc_nxt;
  logic       ce_n_nxt, oe_n_nxt, we_n_nxt;

  always_comb begin
    cpu_pend   = cpu_req & ~cpu_served;
    cpu_stall  = cpu_pend;
    acc_last   = (acc_cnt == ACC_LAST);
    grant_cpu  = 1'b0;
    grant_lcd  = 1'b0;
    state_nxt  = state;
    acc_nxt    = acc_cnt;
    case (state)
      IDLE: begin
        if (cpu_pend && lcd_req && (starve_cnt >= STARVE_LIM)) grant_lcd = 1'b1;
        else if (cpu_pend)                                      grant_cpu = 1'b1;
        else if (lcd_req)                                       grant_lcd = 1'b1;
        if (grant_cpu) begin
          state_nxt = CPU_ACC;
          acc_nxt   = 4'd0;
        end else if (grant_lcd) begin
          state_nxt = LCD_ACC;
          acc_nxt   = 4'd0;
        end
      end
      CPU_ACC, LCD_ACC: begin
        if (acc_last) state_nxt = TURN;
        else          acc_nxt   = acc_cnt + 4'd1;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    we_nxt = grant_cpu ? cpu_we : (grant_lcd ? 1'b0 : acc_we);

    // Strobes are computed from the next state so they come straight off flops.
    in_acc_nxt = (state_nxt == CPU_ACC) || (state_nxt == LCD_ACC);
    ce_n_nxt   = ~in_acc_nxt;
    oe_n_nxt   = ~(in_acc_nxt & ~we_nxt);
    we_n_nxt   = ~(in_acc_nxt & we_nxt & (acc_nxt >= 4'd1) & (acc_nxt <= WE_LAST));
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state      <= IDLE;
      acc_cnt    <= 4'd0;
      acc_we     <= 1'b0;
      starve_cnt <= 8'd0;
      cpu_served <= 1'b0;
      mem_addr   <= 22'd0;
      mem_wdata  <= 8'd0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
      cpu_rdata  <= 8'd0;
      lcd_rdata  <= 8'd0;
      cpu_done   <= 1'b0;
      lcd_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc_cnt  <= acc_nxt;
      acc_we   <= we_nxt;
      mem_ce_n <= ce_n_nxt;
      mem_oe_n <= oe_n_nxt;
      mem_we_n <= we_n_nxt;
      cpu_done <= 1'b0;
      lcd_done <= 1'b0;

      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (grant_lcd) begin
        mem_addr  <= lcd_addr;
      end

      if (state == CPU_ACC && acc_last) begin
        cpu_done <= 1'b1;
        if (!acc_we) cpu_rdata <= mem_rdata;
      end
      if (state == LCD_ACC && acc_last) begin
        lcd_done  <= 1'b1;
        lcd_rdata <= mem_rdata;
      end

      if (!lcd_req || grant_lcd)                         starve_cnt <= 8'd0;
      else if (state != LCD_ACC && starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;

      // A held request is served once; it must drop before it can be served again.
      if (!cpu_req)                          cpu_served <= 1'b0;
      else if (state == CPU_ACC && acc_last) cpu_served <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blink_mem_arbiter.sv
// Bench for blink_mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a timeline model of grants and access phases.
module tb_blink_mem_arbiter;
  localparam int ACC  = 3;
  localparam int SMAX = 8;

  logic        mck = 1'b0;
  logic        rin_n;
  logic        cpu_req, cpu_we, lcd_req;
  logic [21:0] cpu_addr, lcd_addr, mem_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, lcd_rdata, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, lcd_done, mem_ce_n, mem_oe_n, mem_we_n;

  blink_mem_arbiter #(.ACC_CYCLES(ACC), .STARVE_MAX(SMAX)) dut (
    .mck(mck), .rin_n(rin_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_rdata(lcd_rdata), .lcd_done(lcd_done),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 mck = ~mck;

  function automatic logic [7:0] rd(input logic [21:0] a);
    if (a == 22'h080123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C;
  endfunction

  assign mem_rdata = rd(mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: owner of the current access (0 none, 1 cpu, 2 lcd) and edges since its grant.
  int          m_own, m_ph, m_starve;
  logic        m_we, m_served, m_cdone, m_ldone;
  logic [21:0] m_addr;
  logic [7:0]  m_wd, m_crd, m_lrd;

  task automatic m_reset();
    m_own = 0; m_ph = 0; m_starve = 0;
    m_we = 1'b0; m_served = 1'b0; m_cdone = 1'b0; m_ldone = 1'b0;
    m_addr = 22'd0; m_wd = 8'd0; m_crd = 8'd0; m_lrd = 8'd0;
  endtask

  task automatic m_step();
    int e, g;
    bit idle, lacc, fin, pend;
    if (!rin_n) begin
      m_reset();
      return;
    end
    e    = m_ph + 1;
    idle = (m_own == 0) || (e >= ACC + 2);
    lacc = (m_own == 2) && (e <= ACC);
    fin  = (m_own != 0) && (e == ACC);
    pend = cpu_req && !m_served;
    g = 0;
    if (idle) begin
      if (pend && lcd_req && m_starve >= SMAX) g = 2;
      else if (pend)                           g = 1;
      else if (lcd_req)                        g = 2;
    end
    m_cdone = 1'b0;
    m_ldone = 1'b0;
    if (fin && m_own == 1) begin
      m_cdone = 1'b1;
      if (!m_we) m_crd = rd(m_addr);
    end
    if (fin && m_own == 2) begin
      m_ldone = 1'b1;
      m_lrd   = rd(m_addr);
    end
    if (!cpu_req)                m_served = 1'b0;
    else if (fin && m_own == 1)  m_served = 1'b1;
    if (!lcd_req || g == 2)               m_starve = 0;
    else if (!lacc && m_starve < 255)     m_starve++;
    if (g != 0) begin
      m_own  = g;
      m_ph   = 0;
      m_addr = (g == 1) ? cpu_addr : lcd_addr;
      m_we   = (g == 1) && cpu_we;
      if (g == 1) m_wd = cpu_wdata;
    end else if (m_own != 0) begin
      m_ph = e;
      if (idle) m_own = 0;
    end
  endtask

  task automatic chk_all();
    bit act;
    act = (m_own != 0) && (m_ph <= ACC - 1);
    chk("ce_n",      mem_ce_n,  !act);
    chk("oe_n",      mem_oe_n,  !(act && !m_we));
    chk("we_n",      mem_we_n,  !(act && m_we && m_ph >= 1 && m_ph <= ACC - 2));
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wd);
    chk("cpu_done",  cpu_done,  m_cdone);
    chk("lcd_done",  lcd_done,  m_ldone);
    chk("cpu_rdata", cpu_rdata, m_crd);
    chk("lcd_rdata", lcd_rdata, m_lrd);
    chk("cpu_stall", cpu_stall, cpu_req && !m_served);
  endtask

  task automatic tick();
    @(posedge mck);
    m_step();
    #1;
    chk_all();
  endtask

  initial begin
    int done_at, ce_cnt, we_cnt, oe_cnt, ncpu, tc, tl, nl, nf;
    int falls[4];
    bit pce, seen, c_got;

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 22'd0; cpu_wdata = 8'd0;
    lcd_req = 1'b0; lcd_addr = 22'd0;
    rin_n = 1'b1;
    m_reset();
    #1 rin_n = 1'b0;
    #1 chk_all();
    tick(); tick();
    rin_n = 1'b1;
    tick();

    // Single CPU read.
    cpu_we = 1'b0; cpu_addr = 22'h080123; cpu_wdata = 8'($urandom); cpu_req = 1'b1;
    #1 chk("stall_on_req", cpu_stall, 1'b1);
    done_at = 0; ce_cnt = 0; oe_cnt = 0;
    for (int i = 1; i <= 10 && done_at == 0; i++) begin
      tick();
      if (!mem_ce_n) ce_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (cpu_done) done_at = i;
    end
    chk("rd_done_latency", done_at, 4);
    chk("rd_ce_cycles", ce_cnt, 3);
    chk("rd_oe_cycles", oe_cnt, 3);
    chk("rd_data", cpu_rdata, 8'h5A);
    chk("rd_stall_at_done", cpu_stall, 1'b0);
    cpu_req = 1'b0;
    tick(); tick();

    // CPU write, request held past done.
    cpu_we = 1'b1; cpu_addr = 22'h200010; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    done_at = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
    for (int i = 1; i <= 10 && done_at == 0; i++) begin
      tick();
      if (!mem_ce_n) ce_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n) we_cnt++;
      if (cpu_done) done_at = i;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!mem_ce_n) ce_cnt++;
    end
    chk("wr_done_latency", done_at, 4);
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_oe_cycles", oe_cnt, 0);
    chk("wr_ce_single_access", ce_cnt, 3);
    chk("wr_wdata", mem_wdata, 8'hA5);
    chk("wr_keeps_rdata", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    tick(); tick();

    // Starvation guard: continuous LCD request against repeated CPU requests.
    cpu_we = 1'b0; cpu_addr = 22'($urandom); lcd_addr = 22'h300000;
    cpu_req = 1'b1; lcd_req = 1'b1;
    ncpu = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (lcd_done) seen = 1'b1;
      else if (cpu_done) begin
        ncpu++;
        cpu_req = 1'b0;
      end else if (!cpu_req) begin
        cpu_req = 1'b1;
        cpu_addr = 22'($urandom);
      end
    end
    chk("starve_lcd_served", seen, 1'b1);
    chk("starve_cpu_wins_first", ncpu, 2);
    lcd_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (cpu_done) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    tick();

    // LCD streaming 0..3.
    lcd_addr = 22'd0; lcd_req = 1'b1;
    nl = 0; nf = 0; pce = 1'b1;
    for (int i = 0; i < 40 && nl < 4; i++) begin
      tick();
      if (pce && !mem_ce_n) begin
        if (nf < 4) falls[nf] = i;
        nf++;
      end
      pce = mem_ce_n;
      if (lcd_done) begin
        chk("lcd_stream_data", lcd_rdata, rd(22'(nl)));
        nl++;
        if (nl == 4) lcd_req = 1'b0;
        else         lcd_addr = 22'(nl);
      end
    end
    chk("lcd_stream_count", nl, 4);
    chk("lcd_stream_ce_falls", nf, 4);
    for (int k = 1; k < 4; k++) chk("lcd_stream_spacing", falls[k] - falls[k-1], 5);
    tick(); tick();

    // Reset in the middle of a CPU write.
    cpu_we = 1'b1; cpu_addr = 22'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1'b1;
    tick(); tick();
    chk("rst_we_active_before", mem_we_n, 1'b0);
    rin_n = 1'b0;
    m_reset();
    #1;
    chk("rst_ce_async", mem_ce_n, 1'b1);
    chk("rst_oe_async", mem_oe_n, 1'b1);
    chk("rst_we_async", mem_we_n, 1'b1);
    chk("rst_no_done", cpu_done, 1'b0);
    tick(); tick();
    rin_n = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 10 && done_at == 0; i++) begin
      tick();
      if (cpu_done) done_at = i;
    end
    chk("rst_restart_latency", done_at, 4);
    cpu_req = 1'b0;
    tick(); tick();

    // Simultaneous requests with no starvation.
    cpu_we = 1'b0; cpu_addr = 22'($urandom); lcd_addr = 22'($urandom);
    cpu_req = 1'b1; lcd_req = 1'b1;
    tc = -1; tl = -1;
    for (int i = 0; i < 30 && tl < 0; i++) begin
      tick();
      if (cpu_done) begin tc = i; cpu_req = 1'b0; end
      if (lcd_done) begin tl = i; lcd_req = 1'b0; end
    end
    chk("both_cpu_first", (tc >= 0) && (tc < tl), 1'b1);
    chk("both_done_spacing", tl - tc, 5);
    cpu_req = 1'b0; lcd_req = 1'b0;
    tick(); tick();

    // Random traffic obeying the request protocols.
    c_got = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (cpu_done) c_got = 1'b1;
      if (cpu_req && c_got && $urandom_range(0, 1) == 1) begin
        cpu_req = 1'b0;
        c_got = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 22'($urandom);
        cpu_wdata = 8'($urandom);
      end
      if (lcd_req && lcd_done && $urandom_range(0, 1) == 1) lcd_req = 1'b0;
      else if (lcd_req && lcd_done) lcd_addr = 22'($urandom);
      else if (!lcd_req && $urandom_range(0, 2) == 0) begin
        lcd_req  = 1'b1;
        lcd_addr = 22'($urandom);
      end
    end
    lcd_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (cpu_done) c_got = 1'b1;
      if (c_got) cpu_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
